// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into a single ready/valid event stream:
// fresh presses (lowest index first) plus auto-repeat for the last granted button.
module button_event_ctrl #(
  parameter int N_BTN         = 4,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         clean,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_repeat,
  output logic                     dropped
);

  localparam int          ID_W        = $clog2(N_BTN);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t            state_q, state_d;
  logic [N_BTN-1:0]  prev_q;
  logic [N_BTN-1:0]  press_pend_q, press_pend_d;
  logic              dropped_q, dropped_d;
  logic              evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d;
  logic              evt_repeat_q, evt_repeat_d;
  logic [ID_W-1:0]   track_q, track_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              rep_pend_q, rep_pend_d;

  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  gnt_mask;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_pend;
  logic              slot_free;
  logic              fresh_gnt;
  logic              rep_gnt;

  assign rise      = clean & ~prev_q;
  assign any_pend  = |press_pend_q;
  assign slot_free = ~evt_valid_q | evt_ready;
  assign fresh_gnt = slot_free & any_pend;
  assign rep_gnt   = slot_free & ~any_pend & rep_pend_q;

  // Lowest-index pending press wins arbitration.
  always_comb begin
    gnt_mask = '0;
    gnt_idx  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (press_pend_q[k] && (gnt_mask == '0)) begin
        gnt_mask[k] = 1'b1;
        gnt_idx     = ID_W'(k);
      end
    end
  end

  always_comb begin
    // A new rise re-arms a bit being granted on the same edge; that is not a loss.
    press_pend_d = (press_pend_q & ~(fresh_gnt ? gnt_mask : '0)) | rise;
    dropped_d    = dropped_q | (|(rise & press_pend_q & ~(fresh_gnt ? gnt_mask : '0)));
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    evt_repeat_d = evt_repeat_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    track_d      = track_q;
    rep_pend_d   = rep_pend_q & ~rep_gnt;

    if (slot_free) begin
      if (any_pend) begin
        evt_valid_d  = 1'b1;
        evt_id_d     = gnt_idx;
        evt_repeat_d = 1'b0;
      end else if (rep_pend_q) begin
        evt_valid_d  = 1'b1;
        evt_id_d     = track_q;
        evt_repeat_d = 1'b1;
      end else begin
        evt_valid_d  = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        rep_pend_d = 1'b0;
      end
      HOLD: begin
        if (!clean[track_q]) begin
          state_d    = IDLE;
          cnt_d      = '0;
          rep_pend_d = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          rep_pend_d = 1'b1;
          cnt_d      = '0;
          state_d    = REPEAT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      REPEAT: begin
        if (!clean[track_q]) begin
          state_d    = IDLE;
          cnt_d      = '0;
          rep_pend_d = 1'b0;
        end else if (cnt_q == REPEAT_LAST) begin
          rep_pend_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        rep_pend_d = 1'b0;
      end
    endcase

    // A fresh grant retargets the repeat engine and discards any repeat due now.
    if (fresh_gnt) begin
      track_d    = gnt_idx;
      cnt_d      = '0;
      rep_pend_d = 1'b0;
      state_d    = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    prev_q <= clean;
    if (!rst_n) begin
      state_q      <= IDLE;
      press_pend_q <= '0;
      dropped_q    <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
      track_q      <= '0;
      cnt_q        <= '0;
      rep_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      press_pend_q <= press_pend_d;
      dropped_q    <= dropped_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_repeat_q <= evt_repeat_d;
      track_q      <= track_d;
      cnt_q        <= cnt_d;
      rep_pend_q   <= rep_pend_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_repeat = evt_repeat_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: a scoreboard of expected events is
// popped on every handshake, plus cycle-exact checks of the output slot.
module tb_button_event_ctrl;

  localparam int N_BTN = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] clean;
  logic             evt_ready;
  logic             evt_valid;
  logic [1:0]       evt_id;
  logic             evt_repeat;
  logic             dropped;

  typedef struct packed {
    logic [1:0] id;
    logic       rep;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  button_event_ctrl #(
    .N_BTN(N_BTN),
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clean     (clean),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_repeat(evt_repeat),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] id, input logic rep);
    chk({tag, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({tag, "_id"}, 32'(evt_id), 32'(id));
      chk({tag, "_rep"}, 32'(evt_repeat), 32'(rep));
    end
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) begin
      tick();
      chk(tag, 32'(evt_valid), 32'd0);
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_evt observed id=%0d rep=%0d expected=none", evt_id, evt_repeat);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("sb_id", 32'(evt_id), 32'(e.id));
        chk("sb_rep", 32'(evt_repeat), 32'(e.rep));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    clean     = '0;
    evt_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_rep", 32'(evt_repeat), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    rst_n = 1'b1;

    // Single press, two-edge latency, one-cycle event.
    evt_ready = 1'b1;
    clean = 4'b0100;
    sb.push_back(ev_t'{id: 2'd2, rep: 1'b0});
    tick(); expect_out("p2_e0", 1'b0, 2'd0, 1'b0);
    tick(); expect_out("p2_e1", 1'b1, 2'd2, 1'b0);
    tick(); expect_out("p2_e2", 1'b0, 2'd0, 1'b0);
    clean = 4'b0000;
    idle("p2_idle", 15);

    // Simultaneous presses: lowest index first, back to back.
    clean = 4'b1010;
    sb.push_back(ev_t'{id: 2'd1, rep: 1'b0});
    sb.push_back(ev_t'{id: 2'd3, rep: 1'b0});
    tick(); expect_out("dual_e0", 1'b0, 2'd0, 1'b0);
    tick(); expect_out("dual_e1", 1'b1, 2'd1, 1'b0);
    tick(); expect_out("dual_e2", 1'b1, 2'd3, 1'b0);
    tick(); expect_out("dual_e3", 1'b0, 2'd0, 1'b0);
    clean = 4'b0000;
    idle("dual_idle", 15);

    // Held button: press, first repeat after hold period, then periodic repeats.
    clean = 4'b0001;
    sb.push_back(ev_t'{id: 2'd0, rep: 1'b0});
    repeat (3) sb.push_back(ev_t'{id: 2'd0, rep: 1'b1});
    tick(); expect_out("hold_e0", 1'b0, 2'd0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      expect_out($sformatf("hold_e%0d", k), (k == 1 || k == 10 || k == 14 || k == 18),
                 2'd0, (k != 1));
    end
    clean = 4'b0000;
    idle("hold_idle", 12);

    // Stalled consumer: event stays stable, repeats coalesce into one.
    evt_ready = 1'b0;
    clean = 4'b0010;
    sb.push_back(ev_t'{id: 2'd1, rep: 1'b0});
    sb.push_back(ev_t'{id: 2'd1, rep: 1'b1});
    tick(); expect_out("stall_e0", 1'b0, 2'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      expect_out($sformatf("stall_e%0d", k), 1'b1, 2'd1, 1'b0);
    end
    evt_ready = 1'b1;
    clean = 4'b0000;
    tick(); expect_out("stall_rep", 1'b1, 2'd1, 1'b1);
    tick(); expect_out("stall_done", 1'b0, 2'd0, 1'b0);
    idle("stall_idle", 10);
    chk("stall_dropped", 32'(dropped), 32'd0);

    // Double pulse on button 3 while the slot is blocked: coalesced and flagged.
    evt_ready = 1'b0;
    clean = 4'b0001;
    sb.push_back(ev_t'{id: 2'd0, rep: 1'b0});
    tick();
    tick(); expect_out("drop_held", 1'b1, 2'd0, 1'b0);
    clean = 4'b1001; tick();
    clean = 4'b0001; tick();
    chk("drop_before", 32'(dropped), 32'd0);
    clean = 4'b1001; tick();
    tick();
    chk("drop_after", 32'(dropped), 32'd1);
    expect_out("drop_stable", 1'b1, 2'd0, 1'b0);
    sb.push_back(ev_t'{id: 2'd3, rep: 1'b0});
    clean = 4'b0000;
    evt_ready = 1'b1;
    tick(); expect_out("drop_id3", 1'b1, 2'd3, 1'b0);
    tick(); expect_out("drop_done", 1'b0, 2'd0, 1'b0);
    idle("drop_idle", 10);
    chk("drop_sticky", 32'(dropped), 32'd1);

    // Reset mid-handshake with the button held: event discarded, no re-trigger.
    evt_ready = 1'b0;
    clean = 4'b0001;
    tick();
    tick(); expect_out("rst2_held", 1'b1, 2'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", 32'(evt_valid), 32'd0);
    chk("rst2_id", 32'(evt_id), 32'd0);
    chk("rst2_rep", 32'(evt_repeat), 32'd0);
    chk("rst2_dropped", 32'(dropped), 32'd0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    idle("rst2_quiet", 12);
    clean = 4'b0000;
    tick();
    tick();
    clean = 4'b0001;
    sb.push_back(ev_t'{id: 2'd0, rep: 1'b0});
    tick(); expect_out("rst2_e0", 1'b0, 2'd0, 1'b0);
    tick(); expect_out("rst2_e1", 1'b1, 2'd0, 1'b0);
    tick(); expect_out("rst2_e2", 1'b0, 2'd0, 1'b0);
    clean = 4'b0000;
    idle("rst2_idle", 5);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
